// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

   localparam int unsigned INST_W        = 32;
   localparam logic [31:0] RESET_PC_DFLT = 32'hbfc0_0000;
   localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } fs_state_e;

endpackage

// File: rtl/fs_out_slot.sv
// One-entry fetch output register toward decode: valid/allowin handshake with flush and load.
module fs_out_slot
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_pc,
   input  logic [INST_W-1:0] i_load_inst,
   input  logic              i_load_adel,
   input  logic              i_allowin,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_pc,
   output logic [INST_W-1:0] o_inst,
   output logic              o_adel
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_pc;
   logic [INST_W-1:0] r_inst;
   logic              r_adel;

   // Flush beats both refill and consume; payload only moves on a load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_inst  <= INST_NOP;
         r_adel  <= 1'b0;
      end else begin
         if (i_flush) begin
            r_valid <= 1'b0;
         end else if (i_load) begin
            r_valid <= 1'b1;
         end else if (i_allowin) begin
            r_valid <= 1'b0;
         end
         if (i_load && !i_flush) begin
            r_pc   <= i_load_pc;
            r_inst <= i_load_inst;
            r_adel <= i_load_adel;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_inst  = r_inst;
   assign o_adel  = r_adel;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the instruction SRAM handshake,
// applies redirects and cancels stale in-flight fetches.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DFLT)
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              ex_valid,
   input  logic [ADDR_W-1:0] ex_target,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [INST_W-1:0] inst_rdata,
   input  logic              ds_allowin,
   output logic              fs_valid,
   output logic [ADDR_W-1:0] fs_pc,
   output logic [INST_W-1:0] fs_inst,
   output logic              fs_adel
);

   fs_state_e         r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic [ADDR_W-1:0] r_req_pc, w_req_pc_nxt;
   logic [ADDR_W-1:0] r_pend_tgt, w_pend_tgt_nxt;
   logic              r_cancel, w_cancel_nxt;
   logic              r_redir_pend, w_redir_pend_nxt;
   logic              r_req_held, w_req_held_nxt;

   logic              w_redir;
   logic [ADDR_W-1:0] w_target;
   logic              w_slot_free;
   logic              w_aligned;
   logic              w_req;

   logic              w_load;
   logic [ADDR_W-1:0] w_load_pc;
   logic [INST_W-1:0] w_load_inst;
   logic              w_load_adel;

   assign w_redir     = ex_valid | br_valid;
   assign w_target    = ex_valid ? ex_target : br_target;
   assign w_slot_free = !fs_valid || ds_allowin;
   assign w_aligned   = (r_pc[1:0] == 2'b00);

   // A request once raised stays up until accepted, regardless of decode backpressure.
   assign w_req     = (r_state == S_REQ) && w_aligned && (r_req_held || w_slot_free);
   assign inst_req  = w_req;
   assign inst_addr = r_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_req_pc     <= '0;
         r_pend_tgt   <= '0;
         r_cancel     <= 1'b0;
         r_redir_pend <= 1'b0;
         r_req_held   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_req_pc     <= w_req_pc_nxt;
         r_pend_tgt   <= w_pend_tgt_nxt;
         r_cancel     <= w_cancel_nxt;
         r_redir_pend <= w_redir_pend_nxt;
         r_req_held   <= w_req_held_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_req_pc_nxt     = r_req_pc;
      w_pend_tgt_nxt   = r_pend_tgt;
      w_cancel_nxt     = r_cancel;
      w_redir_pend_nxt = r_redir_pend;
      w_req_held_nxt   = 1'b0;
      w_load           = 1'b0;
      w_load_pc        = r_pc;
      w_load_inst      = INST_NOP;
      w_load_adel      = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
         end

         S_REQ: begin
            if (w_req) begin
               if (inst_addr_ok) begin
                  w_state_nxt      = S_WAIT;
                  w_req_pc_nxt     = r_pc;
                  w_redir_pend_nxt = 1'b0;
                  if (w_redir) begin
                     w_cancel_nxt = 1'b1;
                     w_pc_nxt     = w_target;
                  end else if (r_redir_pend) begin
                     w_cancel_nxt = 1'b1;
                     w_pc_nxt     = r_pend_tgt;
                  end else begin
                     w_pc_nxt = r_pc + ADDR_W'(4);
                  end
               end else begin
                  w_req_held_nxt = 1'b1;
                  if (w_redir) begin
                     w_redir_pend_nxt = 1'b1;
                     w_pend_tgt_nxt   = w_target;
                  end
               end
            end else if (w_redir) begin
               w_pc_nxt = w_target;
            end else if (!w_aligned && w_slot_free) begin
               // Misaligned PC: hand decode an address-error marker instead of fetching.
               w_load      = 1'b1;
               w_load_pc   = r_pc;
               w_load_inst = INST_NOP;
               w_load_adel = 1'b1;
            end
         end

         S_WAIT: begin
            if (w_redir) begin
               w_pc_nxt = w_target;
               if (inst_data_ok) begin
                  // Response already here: drop it now, nothing left to cancel.
                  w_cancel_nxt = 1'b0;
                  w_state_nxt  = S_REQ;
               end else begin
                  w_cancel_nxt = 1'b1;
               end
            end else if (inst_data_ok) begin
               w_state_nxt = S_REQ;
               if (r_cancel) begin
                  w_cancel_nxt = 1'b0;
               end else begin
                  w_load      = 1'b1;
                  w_load_pc   = r_req_pc;
                  w_load_inst = inst_rdata;
                  w_load_adel = 1'b0;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   fs_out_slot #(
      .ADDR_W (ADDR_W)
   ) u_out_slot (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (w_redir),
      .i_load      (w_load),
      .i_load_pc   (w_load_pc),
      .i_load_inst (w_load_inst),
      .i_load_adel (w_load_adel),
      .i_allowin   (ds_allowin),
      .o_valid     (fs_valid),
      .o_pc        (fs_pc),
      .o_inst      (fs_inst),
      .o_adel      (fs_adel)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl against an architectural PC-stream model.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'hbfc0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        br_valid, ex_valid;
   logic [31:0] br_target, ex_target;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        ds_allowin;
   logic        fs_valid;
   logic [31:0] fs_pc, fs_inst;
   logic        fs_adel;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .br_valid     (br_valid),
      .br_target    (br_target),
      .ex_valid     (ex_valid),
      .ex_target    (ex_target),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .ds_allowin   (ds_allowin),
      .fs_valid     (fs_valid),
      .fs_pc        (fs_pc),
      .fs_inst      (fs_inst),
      .fs_adel      (fs_adel)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] sram_q[$];
   int unsigned sram_lat;
   bit          hold_data;
   int          n_checks, n_pass, n_deliver;

   // Monitor's record of the previous sample.
   bit          m_acc, m_dok, m_req_hold, m_hold_fs, m_redir;
   logic [31:0] m_addr, m_fs_pc, m_fs_inst;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   function automatic exp_t mk_exp(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.adel = (pc[1:0] != 2'b00);
      e.inst = e.adel ? 32'h0 : mem(pc);
      return e;
   endfunction

   function automatic logic [31:0] pick_target();
      int unsigned r;
      logic [31:0] t;
      r = $urandom_range(0, 19);
      if (r == 0) t = 32'hffff_fff8;
      else        t = RST_PC + (32'($urandom_range(0, 255)) << 2);
      if (r >= 16) t[1:0] = 2'($urandom_range(1, 3));
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // One cycle of stimulus: SRAM responder, decode backpressure, random redirects.
   task automatic step(input bit allow_redir);
      @(posedge clk);
      #1;
      if (m_dok && sram_q.size() != 0) void'(sram_q.pop_front());
      if (m_acc) begin
         sram_q.push_back(m_addr);
         sram_lat = $urandom_range(0, 2);
      end
      ds_allowin = ($urandom_range(0, 3) != 0);
      br_target  = pick_target();
      ex_target  = pick_target();
      br_valid   = allow_redir && ($urandom_range(0, 13) == 0);
      ex_valid   = allow_redir && ($urandom_range(0, 19) == 0);
      if (br_valid || ex_valid) begin
         exp_q.delete();
         exp_q.push_back(mk_exp(ex_valid ? ex_target : br_target));
      end
      if (sram_q.size() != 0 && !hold_data && sram_lat == 0) begin
         inst_data_ok = 1'b1;
         inst_rdata   = mem(sram_q[0]);
      end else begin
         inst_data_ok = 1'b0;
         inst_rdata   = $urandom();
         if (sram_q.size() != 0 && sram_lat > 0) sram_lat--;
      end
      #1;
      inst_addr_ok = inst_req && ($urandom_range(0, 2) != 0);
   endtask

   // Monitor: protocol checks and scoreboard comparison of each instruction decode accepts.
   always @(negedge clk) begin
      if (rst) begin
         m_acc = 0; m_dok = 0; m_req_hold = 0; m_hold_fs = 0; m_redir = 0;
      end else begin
         if (m_req_hold) begin
            chk("req_held", 32'(inst_req), 32'd1);
            chk("addr_held", inst_addr, m_addr);
         end else if (inst_req) begin
            chk("req_needs_free_slot", 32'(fs_valid && !ds_allowin), 32'd0);
         end
         if (m_hold_fs) begin
            chk("fs_valid_held", 32'(fs_valid), 32'd1);
            chk("fs_pc_held", fs_pc, m_fs_pc);
            chk("fs_inst_held", fs_inst, m_fs_inst);
         end
         if (m_redir) chk("flush", 32'(fs_valid), 32'd0);
         if (fs_valid && ds_allowin && !(br_valid || ex_valid)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_delivery", fs_pc, 32'hxxxx_xxxx);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("fs_pc", fs_pc, e.pc);
               chk("fs_inst", fs_inst, e.inst);
               chk("fs_adel", 32'(fs_adel), 32'(e.adel));
               n_deliver++;
               exp_q.push_back(e.adel ? e : mk_exp(e.pc + 32'd4));
            end
         end
         m_acc      = inst_req && inst_addr_ok;
         m_req_hold = inst_req && !inst_addr_ok;
         m_addr     = inst_addr;
         m_dok      = inst_data_ok;
         m_redir    = br_valid || ex_valid;
         m_hold_fs  = fs_valid && !ds_allowin && !(br_valid || ex_valid);
         m_fs_pc    = fs_pc;
         m_fs_inst  = fs_inst;
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_inst_req"}, 32'(inst_req), 32'd0);
      chk({tag, "_inst_addr"}, inst_addr, RST_PC);
      chk({tag, "_fs_valid"}, 32'(fs_valid), 32'd0);
      chk({tag, "_fs_pc"}, fs_pc, 32'd0);
      chk({tag, "_fs_inst"}, fs_inst, 32'd0);
      chk({tag, "_fs_adel"}, 32'(fs_adel), 32'd0);
   endtask

   initial begin
      n_checks = 0; n_pass = 0; n_deliver = 0;
      sram_lat = 0; hold_data = 0;
      rst = 1'b1;
      br_valid = 0; ex_valid = 0; br_target = '0; ex_target = '0;
      inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0; ds_allowin = 1'b1;
      exp_q.push_back(mk_exp(RST_PC));
      #12;
      chk_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 10; i++) step(1'b0);
      for (int i = 0; i < 4000; i++) step(1'b1);

      // Park a fetch in the wait state, then reset asynchronously mid-transaction.
      hold_data = 1'b1;
      begin
         int k;
         for (k = 0; k < 50; k++) begin
            step(1'b0);
            if (sram_q.size() != 0) break;
         end
         chk("reach_wait", 32'(sram_q.size() != 0), 32'd1);
      end
      rst = 1'b1;
      #1;
      chk_reset_outputs("mid_reset");
      sram_q.delete();
      exp_q.delete();
      exp_q.push_back(mk_exp(RST_PC));
      hold_data = 1'b0;
      inst_addr_ok = 0; inst_data_ok = 0; br_valid = 0; ex_valid = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      // Stray response while idle must be ignored.
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hdead_beef;
      ds_allowin   = 1'b1;
      for (int i = 0; i < 300; i++) step(1'b1);

      chk("progress", 32'(n_deliver >= 100), 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
